wave_loader: RTL and testbench
==============================

Name: wave_loader

Overview:
- Write-side companion to the signal generator's address counter and waveform-RAM read path.
- Accepts a stream of samples over a valid/ready handshake and writes them into the waveform RAM write port at sequential addresses 0..len.
- The RAM can be reloaded at runtime without halting the read-side counter.
- Sits between the host/test-pattern source and the RAM write port.

Parameters:
- A_WIDTH, 8, RAM address width; table depth is 2^A_WIDTH.
- D_WIDTH, 8, sample/data width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  1-cycle request to begin a load; sampled only in IDLE.
- len  input  A_WIDTH  number of samples minus 1; captured on accepted start.
- abort  input  1  terminate an in-progress load.
- in_valid  input  1  source has a sample on in_data.
- in_data  input  D_WIDTH  sample value.
- in_ready  output  1  block accepts a sample this cycle.
- wr_en  output  1  RAM write strobe.
- wr_addr  output  A_WIDTH  RAM write address.
- wr_data  output  D_WIDTH  RAM write data.
- busy  output  1  high in LOAD.
- done  output  1  1-cycle pulse when the final sample is written.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - in_ready, wr_en, busy and done are 0.
  - wr_addr, wr_data and the internal address and last-address registers are 0.
- Reset mid-load drops the load immediately; no further writes occur.
- States are IDLE, LOAD and DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1: capture last<=len, set addr<=0, go to LOAD.
  - abort is ignored.
- LOAD:
  - busy=1, in_ready=1 (combinational from state).
  - Handshake is in_valid && in_ready && !abort.
  - On a handshake: wr_en<=1, wr_addr<=addr, wr_data<=in_data, addr<=addr+1 (modulo 2^A_WIDTH).
  - Write latency is 1 cycle: wr_* is valid in the cycle after the handshake.
  - If the handshake occurs with addr==last, go to DONE.
  - A cycle with no handshake gives wr_en<=0, and addr and state hold.
  - in_valid may stall for any number of cycles.
  - abort=1 takes priority over a same-cycle handshake: that sample is not written, wr_en<=0, go to IDLE, done is not pulsed.
- DONE:
  - Lasts exactly 1 cycle. done=1, busy=0, in_ready=0. Then go to IDLE.
  - The final write's wr_en and done are high in the same cycle.
  - start in DONE is ignored.
- wr_en is 0 in every cycle except the one following a handshake.
- Boundaries:
  - len=0 loads exactly one sample.
  - len=2^A_WIDTH-1 loads the full table, addr wraps to 0 after the last write, and no address is written twice.
  - start while in LOAD or DONE is ignored; len is not re-captured.
- wr_data is full width; there is no truncation or sign handling.

Optional Feature:
- Macro: WAVE_LOADER_CKSUM_EN.
- When defined:
  - Extra output port cksum, D_WIDTH wide.
  - cksum is the running sum, modulo 2^D_WIDTH, of all written samples.
  - Cleared to 0 on an accepted start and on reset.
  - Updated with the same timing as wr_data.
  - Holds its value after done until the next start.
  - An aborted load leaves the partial sum.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then start with len=3, in_valid held high with data 0x10,0x20,0x30,0x40 -> wr_en on 4 consecutive cycles at addr 0..3 with matching data; done=1 coincident with the addr 3 write; busy falls the same cycle; cksum=0xA0.
2. len=0, one sample 0x5A -> single write at addr 0, done pulse, return to IDLE; in_ready=0 afterwards.
3. len=3 with in_valid toggling 1,0,0,1,0,1,1 -> writes only after valid cycles, addresses 0,1,2,3 contiguous, no wr_en during gaps.
4. len=255 (A_WIDTH=8), 256 samples with data equal to index -> 256 writes addr 0..255, done on the last; an immediate restart writes from addr 0 again.
5. Abort asserted together with in_valid on the third sample of a len=7 load -> only addrs 0,1 written; no done; busy=0 next cycle; a fresh start loads from addr 0.
6. rst pulled low mid-load after 2 writes, then released -> all outputs 0 immediately; start is required to resume; no stray wr_en.

Source files
------------

// File: rtl/wave_loader.sv
// Waveform RAM loader: takes samples over valid/ready and writes them to addresses 0..len.
// Optional running checksum output enabled by defining WAVE_LOADER_CKSUM_EN.
module wave_loader #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] len,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0] wr_data,
  output logic               busy,
`ifdef WAVE_LOADER_CKSUM_EN
  output logic [D_WIDTH-1:0] cksum,
`endif
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t             state_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [A_WIDTH-1:0] addr_d;
  logic [A_WIDTH-1:0] last_q;
  logic               wr_en_q;
  logic [A_WIDTH-1:0] wr_addr_q;
  logic [D_WIDTH-1:0] wr_data_q;
  logic               hs;

  // abort wins over a same-cycle handshake, so the sample is dropped
  assign hs     = in_valid && (state_q == S_LOAD) && !abort;
  assign addr_d = addr_q + 1'b1;

`ifdef WAVE_LOADER_CKSUM_EN
  logic [D_WIDTH-1:0] cksum_q;
  logic [D_WIDTH-1:0] cksum_d;

  assign cksum_d = cksum_q + in_data;
  assign cksum   = cksum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cksum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cksum_q <= '0;
    end else if (hs) begin
      cksum_q <= cksum_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            last_q  <= len;
            addr_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (hs) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= in_data;
            addr_q    <= addr_d;
            if (addr_q == last_q) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status outputs decode directly from the state register
  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_wave_loader.sv
// Directed self-checking bench for wave_loader; checksum checks enabled with WAVE_LOADER_CKSUM_EN.
module tb_wave_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
`ifdef WAVE_LOADER_CKSUM_EN
  logic [7:0] cksum;
`endif

  int checks = 0;
  int errors = 0;

  wave_loader #(.A_WIDTH(8), .D_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
`ifdef WAVE_LOADER_CKSUM_EN
    .cksum    (cksum),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One call compares every status/write output against expected values
  task automatic chk_out(input string tag, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic b, input logic dn);
    chk({tag, ".wr_en"}, {31'b0, wr_en}, {31'b0, we});
    if (we) begin
      chk({tag, ".wr_addr"}, {24'b0, wr_addr}, {24'b0, a});
      chk({tag, ".wr_data"}, {24'b0, wr_data}, {24'b0, d});
    end
    chk({tag, ".busy"},     {31'b0, busy},     {31'b0, b});
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, b});
    chk({tag, ".done"},     {31'b0, done},     {31'b0, dn});
  endtask

  logic [7:0] t1_data [4];
  logic       t3_vld  [7];

  initial begin
    t1_data = '{8'h10, 8'h20, 8'h30, 8'h40};
    t3_vld  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0; in_valid = 1'b0; in_data = 8'd0;

    // Reset state
    tick(); tick();
    chk("rst.wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst.wr_addr", {24'b0, wr_addr}, 32'd0);
    chk("rst.wr_data", {24'b0, wr_data}, 32'd0);
    chk_out("rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;

    // Test 1: len=3, continuous valid
    start = 1'b1; len = 8'd3;
    tick();
    chk_out("t1.start", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    start = 1'b0; len = 8'd9;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = t1_data[i];
      tick();
      chk_out($sformatf("t1.w%0d", i), 1'b1, 8'(i), t1_data[i], (i != 3), (i == 3));
    end
    in_valid = 1'b0;
`ifdef WAVE_LOADER_CKSUM_EN
    chk("t1.cksum", {24'b0, cksum}, 32'h0000_00A0);
`endif
    tick();
    chk_out("t1.idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    abort = 1'b1; in_valid = 1'b1;
    tick();
    chk_out("t1.abort_idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    abort = 1'b0; in_valid = 1'b0;

    // Test 2: len=0, single sample
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    chk_out("t2.w0", 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1);
`ifdef WAVE_LOADER_CKSUM_EN
    chk("t2.cksum", {24'b0, cksum}, 32'h0000_005A);
`endif
    tick();
    chk_out("t2.idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_out("t2.idle2", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Test 3: len=3 with stalls on in_valid
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    begin
      int n = 0;
      for (int i = 0; i < 7; i++) begin
        in_valid = t3_vld[i]; in_data = 8'hA0 + 8'(i);
        tick();
        if (t3_vld[i]) begin
          chk_out($sformatf("t3.c%0d", i), 1'b1, 8'(n), 8'hA0 + 8'(i), (n != 3), (n == 3));
          n++;
        end else begin
          chk_out($sformatf("t3.c%0d", i), 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    chk_out("t3.idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Test 4: full table, then start ignored in DONE, then restart from 0
    start = 1'b1; len = 8'd255;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      chk_out($sformatf("t4.w%0d", i), 1'b1, 8'(i), 8'(i), (i != 255), (i == 255));
    end
    in_valid = 1'b0;
`ifdef WAVE_LOADER_CKSUM_EN
    chk("t4.cksum", {24'b0, cksum}, 32'h0000_0080);
`endif
    start = 1'b1; len = 8'd1;
    tick();
    chk_out("t4.done_start_ign", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef WAVE_LOADER_CKSUM_EN
    chk("t4.cksum_hold", {24'b0, cksum}, 32'h0000_0080);
`endif
    tick();
    chk_out("t4.restart", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    chk_out("t4.r0", 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0);
    in_data = 8'hC4;
    tick();
    chk_out("t4.r1", 1'b1, 8'h01, 8'hC4, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();

    // Test 5: abort on third sample of len=7
    start = 1'b1; len = 8'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      tick();
      chk_out($sformatf("t5.w%0d", i), 1'b1, 8'(i), 8'h30 + 8'(i), 1'b1, 1'b0);
    end
    start = 1'b1; len = 8'd0;
    in_data = 8'h32; abort = 1'b1;
    tick();
    chk_out("t5.abort", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
    chk_out("t5.after", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    chk_out("t5.fresh", 1'b1, 8'h00, 8'h99, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();

    // Test 6: asynchronous reset mid-load
    start = 1'b1; len = 8'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'h60 + 8'(i);
      tick();
      chk_out($sformatf("t6.w%0d", i), 1'b1, 8'(i), 8'h60 + 8'(i), 1'b1, 1'b0);
    end
    #2 rst = 1'b0;
    #1;
    chk("t6.rst.wr_addr", {24'b0, wr_addr}, 32'd0);
    chk("t6.rst.wr_data", {24'b0, wr_data}, 32'd0);
    chk_out("t6.rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef WAVE_LOADER_CKSUM_EN
    chk("t6.rst.cksum", {24'b0, cksum}, 32'd0);
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hEE;
      tick();
      chk_out($sformatf("t6.nostart%0d", i), 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0; in_data = 8'h77;
    tick();
    chk_out("t6.resume", 1'b1, 8'h00, 8'h77, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk_out("t6.idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
